// File: rtl/netlist_eval_pkg.sv
// Shared types for the netlist evaluator: opcodes, result codes, FSM states.
package netlist_eval_pkg;

   localparam int unsigned DefaultNumPi    = 5;
   localparam int unsigned DefaultNumWires = 32;

   typedef enum logic [2:0] {
      OpBuf   = 3'd0,
      OpInv   = 3'd1,
      OpAnd2  = 3'd2,
      OpNand2 = 3'd3,
      OpOr2   = 3'd4,
      OpNor2  = 3'd5,
      OpXor2  = 3'd6,
      OpXnor2 = 3'd7
   } gate_op_e;

   typedef enum logic [1:0] {
      ResOk       = 2'd0,
      ResUndefSrc = 2'd1,
      ResBadDst   = 2'd2,
      ResOutUndef = 2'd3
   } res_code_e;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StEval  = 2'd1,
      StDrain = 2'd2,
      StDone  = 2'd3
   } state_e;

endpackage

// File: rtl/netlist_evaluator_if.sv
// Control, gate-record and result signals of the netlist evaluator.
interface netlist_evaluator_if
   import netlist_eval_pkg::*;
#(
   parameter int unsigned NUM_PI    = DefaultNumPi,
   parameter int unsigned NUM_WIRES = DefaultNumWires
);
   localparam int unsigned IDX_W = $clog2(NUM_WIRES);

   logic              start;
   logic [NUM_PI-1:0] pi_vec;
   logic [IDX_W-1:0]  out_sel;
   logic              gate_valid;
   logic              gate_ready;
   gate_op_e          gate_op;
   logic [IDX_W-1:0]  gate_a;
   logic [IDX_W-1:0]  gate_b;
   logic [IDX_W-1:0]  gate_y;
   logic              gate_last;
   logic              res_valid;
   logic              res_ready;
   logic              res_value;
   logic [1:0]        res_code;
   logic              busy;

   modport master (
      output start, pi_vec, out_sel, gate_valid, gate_op, gate_a, gate_b, gate_y, gate_last,
             res_ready,
      input  gate_ready, res_valid, res_value, res_code, busy
   );

   modport slave (
      input  start, pi_vec, out_sel, gate_valid, gate_op, gate_a, gate_b, gate_y, gate_last,
             res_ready,
      output gate_ready, res_valid, res_value, res_code, busy
   );

endinterface

// File: rtl/netlist_gate_alu.sv
// Single-bit evaluation of one gate record; B is ignored for BUF/INV.
module netlist_gate_alu
   import netlist_eval_pkg::*;
(
   input  gate_op_e i_op,
   input  logic     i_a,
   input  logic     i_b,
   output logic     o_y
);

   // Decode the opcode into the cell function.
   always_comb begin
      o_y = 1'b0;
      unique case (i_op)
         OpBuf:   o_y = i_a;
         OpInv:   o_y = ~i_a;
         OpAnd2:  o_y = i_a & i_b;
         OpNand2: o_y = ~(i_a & i_b);
         OpOr2:   o_y = i_a | i_b;
         OpNor2:  o_y = ~(i_a | i_b);
         OpXor2:  o_y = i_a ^ i_b;
         OpXnor2: o_y = ~(i_a ^ i_b);
      endcase
   end

endmodule

// File: rtl/netlist_evaluator.sv
// Evaluates a streamed gate-level netlist against latched primary inputs and
// reports the value of one selected wire, or the first structural error found.
module netlist_evaluator
   import netlist_eval_pkg::*;
#(
   parameter int unsigned NUM_PI    = DefaultNumPi,
   parameter int unsigned NUM_WIRES = DefaultNumWires
) (
   input logic                clk,
   input logic                rst_n,
   netlist_evaluator_if.slave bus
);

   localparam int unsigned      IDX_W      = $clog2(NUM_WIRES);
   localparam logic [IDX_W-1:0] NUM_PI_IDX = IDX_W'(NUM_PI);

   state_e               r_state;
   state_e               w_state_next;
   logic [NUM_WIRES-1:0] r_val;
   logic [NUM_WIRES-1:0] r_def;
   logic [IDX_W-1:0]     r_out_sel;
   res_code_e            r_err;
   res_code_e            w_res_code;

   logic w_accept;
   logic w_hs;
   logic w_two_in;
   logic w_src_err;
   logic w_dst_err;
   logic w_alu_y;

   assign w_accept  = (r_state == StEval) || (r_state == StDrain);
   assign w_hs      = w_accept & bus.gate_valid;
   assign w_two_in  = !(bus.gate_op inside {OpBuf, OpInv});
   // Checks use the pre-edge def bits, so a record sees everything written before it.
   assign w_src_err = !r_def[bus.gate_a] || (w_two_in && !r_def[bus.gate_b]);
   assign w_dst_err = (bus.gate_y < NUM_PI_IDX) || r_def[bus.gate_y];

   netlist_gate_alu u_alu (
      .i_op (bus.gate_op),
      .i_a  (r_val[bus.gate_a]),
      .i_b  (r_val[bus.gate_b]),
      .o_y  (w_alu_y)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic; an error on the last record skips DRAIN.
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:  if (bus.start) w_state_next = StEval;
         StEval: begin
            if (w_hs) begin
               if (bus.gate_last)                  w_state_next = StDone;
               else if (w_src_err || w_dst_err)   w_state_next = StDrain;
            end
         end
         StDrain: if (w_hs && bus.gate_last) w_state_next = StDone;
         StDone:  if (bus.res_ready) w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   // Wire values, defined bits, output select and sticky first error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_val     <= '0;
         r_def     <= '0;
         r_out_sel <= '0;
         r_err     <= ResOk;
      end else if ((r_state == StIdle) && bus.start) begin
         r_val     <= NUM_WIRES'(bus.pi_vec);
         r_def     <= NUM_WIRES'({NUM_PI{1'b1}});
         r_out_sel <= bus.out_sel;
         r_err     <= ResOk;
      end else if ((r_state == StEval) && w_hs) begin
         if (w_src_err) begin
            r_err <= ResUndefSrc;
         end else if (w_dst_err) begin
            r_err <= ResBadDst;
         end else begin
            r_val[bus.gate_y] <= w_alu_y;
            r_def[bus.gate_y] <= 1'b1;
         end
      end
   end

   // Final result code: a stream error wins over an undriven output wire.
   always_comb begin
      w_res_code = ResOk;
      if (r_err != ResOk) begin
         w_res_code = r_err;
      end else if (!r_def[r_out_sel]) begin
         w_res_code = ResOutUndef;
      end
   end

   // Outputs; the result registers are frozen in DONE so these hold until res_ready.
   always_comb begin
      bus.busy       = (r_state != StIdle);
      bus.gate_ready = w_accept;
      bus.res_valid  = (r_state == StDone);
      bus.res_code   = (r_state == StDone) ? w_res_code : ResOk;
      bus.res_value  = ((r_state == StDone) && (w_res_code == ResOk)) ? r_val[r_out_sel] : 1'b0;
   end

endmodule

// File: tb/tb_netlist_evaluator.sv
// Scoreboard bench: the driver pushes model results, a monitor checks each result.
module tb_netlist_evaluator;
   import netlist_eval_pkg::*;

   typedef struct {
      logic [2:0] op;
      int         a;
      int         b;
      int         y;
   } rec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   exp_q[$];
   rec_t net[$];

   netlist_evaluator_if #(.NUM_PI(5), .NUM_WIRES(32)) bus_if ();

   netlist_evaluator #(.NUM_PI(5), .NUM_WIRES(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: walk the record list with plain arrays, first error wins.
   function automatic void model(input logic [4:0] pi, input int sel, output int v,
                                 output int code);
      bit val[32];
      bit def[32];
      bit r;
      int err;
      err = 0;
      for (int i = 0; i < 32; i++) begin
         val[i] = 1'b0;
         def[i] = 1'b0;
      end
      for (int i = 0; i < 5; i++) begin
         val[i] = pi[i];
         def[i] = 1'b1;
      end
      foreach (net[k]) begin
         if (err != 0) continue;
         if (!def[net[k].a] || (net[k].op > 1 && !def[net[k].b])) begin
            err = 1;
            continue;
         end
         if (net[k].y < 5 || def[net[k].y]) begin
            err = 2;
            continue;
         end
         case (net[k].op)
            3'd0:    r = val[net[k].a];
            3'd1:    r = !val[net[k].a];
            3'd2:    r = val[net[k].a] & val[net[k].b];
            3'd3:    r = !(val[net[k].a] & val[net[k].b]);
            3'd4:    r = val[net[k].a] | val[net[k].b];
            3'd5:    r = !(val[net[k].a] | val[net[k].b]);
            3'd6:    r = val[net[k].a] ^ val[net[k].b];
            default: r = !(val[net[k].a] ^ val[net[k].b]);
         endcase
         val[net[k].y] = r;
         def[net[k].y] = 1'b1;
      end
      if (err == 0 && !def[sel]) err = 3;
      v    = (err == 0) ? int'(val[sel]) : 0;
      code = err;
   endfunction

   task automatic add(input logic [2:0] op, input int a, input int b, input int y);
      rec_t r;
      r.op = op;
      r.a  = a;
      r.b  = b;
      r.y  = y;
      net.push_back(r);
   endtask

   task automatic ref_net();
      net.delete();
      add(3'd1, 4, 0, 5);
      add(3'd1, 2, 0, 6);
      add(3'd3, 3, 6, 7);
      add(3'd5, 7, 5, 8);
      add(3'd3, 1, 0, 9);
      add(3'd5, 9, 8, 10);
   endtask

   task automatic present(input int idx);
      bus_if.gate_op   = gate_op_e'(net[idx].op);
      bus_if.gate_a    = 5'(net[idx].a);
      bus_if.gate_b    = 5'(net[idx].b);
      bus_if.gate_y    = 5'(net[idx].y);
      bus_if.gate_last = (idx == net.size() - 1);
   endtask

   task automatic run_net(input logic [4:0] pi, input int sel, input bit toggle,
                          input int hold, input bit poke_start);
      int v, code, idx, cyc, v0, c0;
      bit hs, early, stable;
      model(pi, sel, v, code);
      exp_q.push_back(code * 2 + v);
      @(posedge clk); #1;
      bus_if.start   = 1'b1;
      bus_if.pi_vec  = pi;
      bus_if.out_sel = 5'(sel);
      @(posedge clk); #1;
      bus_if.start = 1'b0;
      idx   = 0;
      cyc   = 0;
      early = 1'b0;
      while (idx < net.size() && cyc < 200) begin
         bus_if.gate_valid = !(toggle && cyc[0]);
         present(idx);
         @(negedge clk);
         hs = bus_if.gate_valid && bus_if.gate_ready;
         if (bus_if.res_valid) early = 1'b1;
         @(posedge clk); #1;
         if (hs) idx++;
         cyc++;
      end
      bus_if.gate_valid = 1'b0;
      bus_if.gate_last  = 1'b0;
      check("records_consumed", idx, net.size());
      check("no_early_valid", int'(early), 0);
      @(negedge clk);
      check("valid_latency", int'(bus_if.res_valid), 1);
      v0     = int'(bus_if.res_value);
      c0     = int'(bus_if.res_code);
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         bus_if.start = poke_start && (i == 1);
         @(negedge clk);
         if (!bus_if.res_valid || int'(bus_if.res_value) != v0 || int'(bus_if.res_code) != c0)
            stable = 1'b0;
      end
      check("hold_stable", int'(stable), 1);
      @(posedge clk); #1;
      bus_if.res_ready = 1'b1;
      bus_if.start     = poke_start;
      @(posedge clk); #1;
      bus_if.res_ready = 1'b0;
      bus_if.start     = 1'b0;
      @(negedge clk);
      check("back_idle", int'(bus_if.busy), 0);
      check("valid_dropped", int'(bus_if.res_valid), 0);
   endtask

   task automatic run_abort();
      @(posedge clk); #1;
      bus_if.start   = 1'b1;
      bus_if.pi_vec  = 5'b11011;
      bus_if.out_sel = 5'd10;
      @(posedge clk); #1;
      bus_if.start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         bus_if.gate_valid = 1'b1;
         present(k);
         @(posedge clk); #1;
      end
      present(3);
      @(negedge clk);
      check("offer_ready", int'(bus_if.gate_ready), 1);
      #2 rst_n = 1'b0;
      #1;
      check("abort_busy", int'(bus_if.busy), 0);
      check("abort_gate_ready", int'(bus_if.gate_ready), 0);
      check("abort_res_valid", int'(bus_if.res_valid), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n             = 1'b1;
      bus_if.gate_valid = 1'b0;
   endtask

   // Monitor: every rising res_valid consumes one scoreboard entry.
   initial begin
      bit prev_valid;
      int e;
      prev_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (bus_if.res_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_result", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("res_value", int'(bus_if.res_value), e % 2);
               check("res_code", int'(bus_if.res_code), e / 2);
            end
         end
         prev_valid = bus_if.res_valid;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n, nxt, sel;
      rec_t r;
      bus_if.start      = 1'b0;
      bus_if.pi_vec     = '0;
      bus_if.out_sel    = '0;
      bus_if.gate_valid = 1'b0;
      bus_if.gate_op    = OpBuf;
      bus_if.gate_a     = '0;
      bus_if.gate_b     = '0;
      bus_if.gate_y     = '0;
      bus_if.gate_last  = 1'b0;
      bus_if.res_ready  = 1'b0;
      #12;
      check("rst_gate_ready", int'(bus_if.gate_ready), 0);
      check("rst_res_valid", int'(bus_if.res_valid), 0);
      check("rst_res_value", int'(bus_if.res_value), 0);
      check("rst_res_code", int'(bus_if.res_code), 0);
      check("rst_busy", int'(bus_if.busy), 0);
      @(negedge clk);
      rst_n = 1'b1;

      ref_net();
      run_net(5'b11011, 10, 1'b0, 0, 1'b0);
      run_net(5'b01011, 10, 1'b0, 0, 1'b0);
      run_net(5'b11010, 10, 1'b0, 0, 1'b0);
      run_net(5'b11011, 10, 1'b1, 5, 1'b0);

      ref_net();
      net[2].b = 12;
      run_net(5'b11011, 10, 1'b0, 1, 1'b0);
      ref_net();
      net[0].y = 2;
      run_net(5'b11011, 10, 1'b0, 0, 1'b0);
      ref_net();
      net[1].y = 5;
      run_net(5'b11011, 10, 1'b0, 0, 1'b0);
      ref_net();
      run_net(5'b11011, 20, 1'b0, 0, 1'b0);

      ref_net();
      run_abort();
      run_net(5'b01011, 10, 1'b0, 0, 1'b0);

      net.delete();
      add(3'd0, 0, 0, 5);
      run_net(5'b00001, 5, 1'b0, 3, 1'b1);
      run_net(5'b10110, 3, 1'b0, 0, 1'b0);

      for (int t = 0; t < 24; t++) begin
         net.delete();
         n   = $urandom_range(1, 8);
         nxt = 5;
         for (int k = 0; k < n; k++) begin
            r.op = 3'($urandom_range(0, 7));
            r.a  = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 31) : $urandom_range(0, nxt - 1);
            r.b  = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 31) : $urandom_range(0, nxt - 1);
            r.y  = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 31) : nxt;
            if (r.y == nxt) nxt++;
            net.push_back(r);
         end
         sel = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 31) : $urandom_range(0, nxt - 1);
         run_net(5'($urandom), sel, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0);
      end

      repeat (3) @(negedge clk);
      check("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
